cs_address_sequencer: RTL and testbench

Microsequencer for the microprogrammed datapath. Each cycle it selects the next control-store address: increment, conditional or unconditional jump, or opcode decode. It holds the address while a memory microoperation waits for ACK, and forces a trap vector if ACK never arrives. It sits between the microinstruction register (COND/JUMPADDR fields), the PSR flags, the IR, and the control-store ROM address input.

---
 rtl/cs_address_sequencer_pkg.sv | 27 ++
 rtl/cs_address_sequencer_if.sv | 47 ++++
 rtl/cs_address_sequencer_mux.sv | 50 +++++
 rtl/cs_address_sequencer.sv | 105 ++++++++++
 tb/tb_cs_address_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/cs_address_sequencer_pkg.sv
// Shared definitions for the control-store address sequencer:
// COND field encodings, FSM state encoding and PSR flag bit positions.
package cs_address_sequencer_pkg;

   typedef enum logic [2:0] {
      COND_NEXT   = 3'd0,
      COND_N      = 3'd1,
      COND_Z      = 3'd2,
      COND_V      = 3'd3,
      COND_C      = 3'd4,
      COND_IR13   = 3'd5,
      COND_JUMP   = 3'd6,
      COND_DECODE = 3'd7
   } cond_t;

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } state_t;

   // PSR flag vector is {N,Z,V,C}
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;

endpackage

// File: rtl/cs_address_sequencer_if.sv
// Signal bundle between the microinstruction/IR/PSR side and the sequencer;
// the sequencer is the slave and returns the control-store address.
interface cs_address_sequencer_if #(
   parameter int CS_DATAWIDTH = 11
);

   logic [2:0]              CS_ADDRESS_SEQUENCER_COND_InBus;
   logic [CS_DATAWIDTH-1:0] CS_ADDRESS_SEQUENCER_JUMPADDR_InBus;
   logic [3:0]              CS_ADDRESS_SEQUENCER_FLAGS_InBus;
   logic [1:0]              CS_ADDRESS_SEQUENCER_IROP_InBus;
   logic [5:0]              CS_ADDRESS_SEQUENCER_IROP3_InBus;
   logic                    CS_ADDRESS_SEQUENCER_IRBIT13_In;
   logic                    CS_ADDRESS_SEQUENCER_MEMREQ_In;
   logic                    CS_ADDRESS_SEQUENCER_ACK_In;
   logic [CS_DATAWIDTH-1:0] CS_ADDRESS_SEQUENCER_CSADDRESS_OutBus;
   logic                    CS_ADDRESS_SEQUENCER_STALL_Out;
   logic                    CS_ADDRESS_SEQUENCER_TIMEOUT_Out;

   modport master (
      output CS_ADDRESS_SEQUENCER_COND_InBus,
      output CS_ADDRESS_SEQUENCER_JUMPADDR_InBus,
      output CS_ADDRESS_SEQUENCER_FLAGS_InBus,
      output CS_ADDRESS_SEQUENCER_IROP_InBus,
      output CS_ADDRESS_SEQUENCER_IROP3_InBus,
      output CS_ADDRESS_SEQUENCER_IRBIT13_In,
      output CS_ADDRESS_SEQUENCER_MEMREQ_In,
      output CS_ADDRESS_SEQUENCER_ACK_In,
      input  CS_ADDRESS_SEQUENCER_CSADDRESS_OutBus,
      input  CS_ADDRESS_SEQUENCER_STALL_Out,
      input  CS_ADDRESS_SEQUENCER_TIMEOUT_Out
   );

   modport slave (
      input  CS_ADDRESS_SEQUENCER_COND_InBus,
      input  CS_ADDRESS_SEQUENCER_JUMPADDR_InBus,
      input  CS_ADDRESS_SEQUENCER_FLAGS_InBus,
      input  CS_ADDRESS_SEQUENCER_IROP_InBus,
      input  CS_ADDRESS_SEQUENCER_IROP3_InBus,
      input  CS_ADDRESS_SEQUENCER_IRBIT13_In,
      input  CS_ADDRESS_SEQUENCER_MEMREQ_In,
      input  CS_ADDRESS_SEQUENCER_ACK_In,
      output CS_ADDRESS_SEQUENCER_CSADDRESS_OutBus,
      output CS_ADDRESS_SEQUENCER_STALL_Out,
      output CS_ADDRESS_SEQUENCER_TIMEOUT_Out
   );

endinterface

// File: rtl/cs_address_sequencer_mux.sv
// Combinational next-address select: increment, conditional/unconditional
// jump, or opcode decode into the dispatch region.
module cs_next_address_mux
   import cs_address_sequencer_pkg::*;
#(
   parameter int CS_DATAWIDTH = 11
) (
   input  logic [2:0]              cond,
   input  logic [CS_DATAWIDTH-1:0] jump_addr,
   input  logic [CS_DATAWIDTH-1:0] current_addr,
   input  logic [3:0]              flags,
   input  logic [1:0]              irop,
   input  logic [5:0]              irop3,
   input  logic                    irbit13,
   output logic [CS_DATAWIDTH-1:0] next_addr
);

   logic                    take_s;
   logic [CS_DATAWIDTH-1:0] incr_s;
   logic [CS_DATAWIDTH-1:0] decode_s;

   // Increment wraps silently at the top of the control store
   assign incr_s   = current_addr + CS_DATAWIDTH'(1'b1);
   assign decode_s = CS_DATAWIDTH'({1'b1, irop, irop3, 2'b00});

   // Evaluate the branch condition and pick the next address
   always_comb begin
      take_s    = 1'b0;
      next_addr = incr_s;
      case (cond_t'(cond))
         COND_NEXT:   take_s = 1'b0;
         COND_N:      take_s = flags[FLAG_N];
         COND_Z:      take_s = flags[FLAG_Z];
         COND_V:      take_s = flags[FLAG_V];
         COND_C:      take_s = flags[FLAG_C];
         COND_IR13:   take_s = irbit13;
         COND_JUMP:   take_s = 1'b1;
         COND_DECODE: take_s = 1'b0;
         default:     take_s = 1'b0;
      endcase
      if (cond_t'(cond) == COND_DECODE) begin
         next_addr = decode_s;
      end else if (take_s) begin
         next_addr = jump_addr;
      end else begin
         next_addr = incr_s;
      end
   end

endmodule

// File: rtl/cs_address_sequencer.sv
// Control-store microsequencer: registers the next address each cycle, holds it
// while a memory microoperation waits for ACK, and traps if ACK never comes.
module cs_address_sequencer
   import cs_address_sequencer_pkg::*;
#(
   parameter int                      CS_DATAWIDTH = 11,
   parameter logic [CS_DATAWIDTH-1:0] RESET_VECTOR = {CS_DATAWIDTH{1'b0}},
   parameter logic [CS_DATAWIDTH-1:0] TRAP_VECTOR  = 11'h7F0,
   parameter int                      WAIT_LIMIT   = 15
) (
   input logic                   CS_ADDRESS_SEQUENCER_CLOCK_50,
   input logic                   CS_ADDRESS_SEQUENCER_RESET_InHigh,
   cs_address_sequencer_if.slave bus
);

   localparam int             WCW       = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LIMIT - 1);

   state_t                  state_r, state_s;
   logic [WCW-1:0]          wait_cnt_r, wait_cnt_s;
   logic [CS_DATAWIDTH-1:0] addr_r, addr_s;
   logic                    timeout_r, timeout_s;
   logic                    stall_s;
   logic [CS_DATAWIDTH-1:0] next_s;
   logic                    memreq_s;
   logic                    ack_s;

   assign memreq_s = bus.CS_ADDRESS_SEQUENCER_MEMREQ_In;
   assign ack_s    = bus.CS_ADDRESS_SEQUENCER_ACK_In;

   cs_next_address_mux #(
      .CS_DATAWIDTH (CS_DATAWIDTH)
   ) u_next_mux (
      .cond         (bus.CS_ADDRESS_SEQUENCER_COND_InBus),
      .jump_addr    (bus.CS_ADDRESS_SEQUENCER_JUMPADDR_InBus),
      .current_addr (addr_r),
      .flags        (bus.CS_ADDRESS_SEQUENCER_FLAGS_InBus),
      .irop         (bus.CS_ADDRESS_SEQUENCER_IROP_InBus),
      .irop3        (bus.CS_ADDRESS_SEQUENCER_IROP3_InBus),
      .irbit13      (bus.CS_ADDRESS_SEQUENCER_IRBIT13_In),
      .next_addr    (next_s)
   );

   // Next-state, next-address, stall and trap decisions
   always_comb begin
      state_s    = state_r;
      wait_cnt_s = wait_cnt_r;
      addr_s     = addr_r;
      timeout_s  = 1'b0;
      stall_s    = 1'b0;
      case (state_r)
         RUN: begin
            if (memreq_s && !ack_s) begin
               stall_s    = 1'b1;
               state_s    = WAIT;
               wait_cnt_s = {WCW{1'b0}};
            end else begin
               addr_s = next_s;
            end
         end
         WAIT: begin
            // ACK on the final permitted cycle still beats the trap
            if (ack_s) begin
               addr_s  = next_s;
               state_s = RUN;
            end else begin
               stall_s = 1'b1;
               if (wait_cnt_r == WAIT_LAST) begin
                  addr_s     = TRAP_VECTOR;
                  timeout_s  = 1'b1;
                  state_s    = RUN;
                  wait_cnt_s = {WCW{1'b0}};
               end else begin
                  wait_cnt_s = wait_cnt_r + WCW'(1'b1);
               end
            end
         end
         default: begin
            state_s    = RUN;
            wait_cnt_s = {WCW{1'b0}};
            addr_s     = RESET_VECTOR;
         end
      endcase
   end

   // State, counter, address and trap pulse registers
   always_ff @(posedge CS_ADDRESS_SEQUENCER_CLOCK_50) begin
      if (CS_ADDRESS_SEQUENCER_RESET_InHigh) begin
         state_r    <= RUN;
         wait_cnt_r <= {WCW{1'b0}};
         addr_r     <= RESET_VECTOR;
         timeout_r  <= 1'b0;
      end else begin
         state_r    <= state_s;
         wait_cnt_r <= wait_cnt_s;
         addr_r     <= addr_s;
         timeout_r  <= timeout_s;
      end
   end

   assign bus.CS_ADDRESS_SEQUENCER_CSADDRESS_OutBus = addr_r;
   assign bus.CS_ADDRESS_SEQUENCER_STALL_Out        = stall_s;
   assign bus.CS_ADDRESS_SEQUENCER_TIMEOUT_Out      = timeout_r;

endmodule

// File: tb/tb_cs_address_sequencer.sv
// Scenario bench for cs_address_sequencer: each task queues the expected
// address/stall/timeout for a cycle as it drives it and checks on the falling edge.
module tb_cs_address_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cs_address_sequencer_if #(.CS_DATAWIDTH(11)) bus ();

   cs_address_sequencer #(
      .CS_DATAWIDTH (11),
      .RESET_VECTOR (11'd0),
      .TRAP_VECTOR  (11'h7F0),
      .WAIT_LIMIT   (15)
   ) dut (
      .CS_ADDRESS_SEQUENCER_CLOCK_50     (clk),
      .CS_ADDRESS_SEQUENCER_RESET_InHigh (rst),
      .bus                               (bus)
   );

   typedef struct {
      logic [10:0] addr;
      logic        stall;
      logic        to;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [10:0] oa;
   logic        os;
   logic        ot;

   task automatic set_ir(input logic [1:0] op, input logic [5:0] op3, input logic b13);
      bus.CS_ADDRESS_SEQUENCER_IROP_InBus  = op;
      bus.CS_ADDRESS_SEQUENCER_IROP3_InBus = op3;
      bus.CS_ADDRESS_SEQUENCER_IRBIT13_In  = b13;
   endtask

   // Drive one cycle of inputs, sample outputs at the falling edge, then pass the rising edge
   task automatic step(input logic [2:0] c, input logic [10:0] j, input logic [3:0] f,
                       input logic m, input logic a);
      bus.CS_ADDRESS_SEQUENCER_COND_InBus     = c;
      bus.CS_ADDRESS_SEQUENCER_JUMPADDR_InBus = j;
      bus.CS_ADDRESS_SEQUENCER_FLAGS_InBus    = f;
      bus.CS_ADDRESS_SEQUENCER_MEMREQ_In      = m;
      bus.CS_ADDRESS_SEQUENCER_ACK_In         = a;
      @(negedge clk);
      oa = bus.CS_ADDRESS_SEQUENCER_CSADDRESS_OutBus;
      os = bus.CS_ADDRESS_SEQUENCER_STALL_Out;
      ot = bus.CS_ADDRESS_SEQUENCER_TIMEOUT_Out;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_ir(2'b00, 6'b000000, 1'b0);
      step(3'd0, 11'd0, 4'h0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      do_reset();
      rst = 1'b1;
      sb.push_back('{11'd0, 1'b1, 1'b0, "reset_stall_eq"});
      step(3'd6, 11'h555, 4'h0, 1'b1, 1'b0);
      e = sb.pop_front(); n_cmp++;
      if ({oa, os, ot} !== {e.addr, e.stall, e.to}) begin
         n_err++;
         $display("FAIL %s: got addr=%h stall=%b timeout=%b, want addr=%h stall=%b timeout=%b", e.tag, oa, os, ot, e.addr, e.stall, e.to);
      end
      sb.push_back('{11'd0, 1'b0, 1'b0, "reset_override"});
      step(3'd0, 11'd0, 4'h0, 1'b0, 1'b0);
      e = sb.pop_front(); n_cmp++;
      if ({oa, os, ot} !== {e.addr, e.stall, e.to}) begin
         n_err++;
         $display("FAIL %s: got addr=%h stall=%b timeout=%b, want addr=%h stall=%b timeout=%b", e.tag, oa, os, ot, e.addr, e.stall, e.to);
      end
      rst = 1'b0;
   endtask

   task automatic test_increment();
      exp_t e;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         sb.push_back('{11'(k), 1'b0, 1'b0, "increment"});
         step(3'd0, 11'h3FF, 4'hF, 1'b0, 1'b0);
         e = sb.pop_front(); n_cmp++;
         if ({oa, os, ot} !== {e.addr, e.stall, e.to}) begin
            n_err++;
            $display("FAIL %s[%0d]: got addr=%h stall=%b timeout=%b, want addr=%h stall=%b timeout=%b", e.tag, k, oa, os, ot, e.addr, e.stall, e.to);
         end
      end
   endtask

   task automatic test_wrap();
      exp_t        e;
      logic [2:0]  tc [4];
      logic [10:0] ta [4];
      tc = '{3'd6, 3'd0, 3'd0, 3'd0};
      ta = '{11'd0, 11'd2047, 11'd0, 11'd1};
      do_reset();
      for (int k = 0; k < 4; k++) begin
         sb.push_back('{ta[k], 1'b0, 1'b0, "wrap"});
         step(tc[k], 11'd2047, 4'h0, 1'b0, 1'b0);
         e = sb.pop_front(); n_cmp++;
         if ({oa, os, ot} !== {e.addr, e.stall, e.to}) begin
            n_err++;
            $display("FAIL %s[%0d]: got addr=%h stall=%b timeout=%b, want addr=%h stall=%b timeout=%b", e.tag, k, oa, os, ot, e.addr, e.stall, e.to);
         end
      end
   endtask

   task automatic test_cond_select();
      exp_t        e;
      logic [2:0]  tc [14];
      logic [10:0] tj [14];
      logic [3:0]  tf [14];
      logic        tb13 [14];
      logic [10:0] ta [14];
      tc   = '{3'd2, 3'd2, 3'd1, 3'd1, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd7, 3'd0, 3'd3, 3'd6, 3'd0};
      tj   = '{11'h123, 11'h123, 11'h200, 11'h200, 11'h300, 11'h400, 11'h400,
               11'h050, 11'h050, 11'h7FF, 11'h7FF, 11'h333, 11'h0AA, 11'h000};
      tf   = '{4'b0100, 4'b1011, 4'b1000, 4'b0111, 4'b0010, 4'b0001, 4'b1110,
               4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1101, 4'b0000, 4'b0000};
      tb13 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      ta   = '{11'h000, 11'h123, 11'h124, 11'h200, 11'h201, 11'h300, 11'h400,
               11'h401, 11'h050, 11'h051, 11'h640, 11'h641, 11'h642, 11'h0AA};
      do_reset();
      for (int k = 0; k < 14; k++) begin
         set_ir(2'b10, 6'b010000, tb13[k]);
         sb.push_back('{ta[k], 1'b0, 1'b0, "cond_select"});
         step(tc[k], tj[k], tf[k], 1'b0, 1'b0);
         e = sb.pop_front(); n_cmp++;
         if ({oa, os, ot} !== {e.addr, e.stall, e.to}) begin
            n_err++;
            $display("FAIL %s[%0d]: got addr=%h stall=%b timeout=%b, want addr=%h stall=%b timeout=%b", e.tag, k, oa, os, ot, e.addr, e.stall, e.to);
         end
      end
   endtask

   task automatic test_stall();
      exp_t        e;
      logic [2:0]  tc [8];
      logic        tm [8];
      logic        tk [8];
      logic [10:0] ta [8];
      logic        ts [8];
      tc = '{3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
      tm = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tk = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      ta = '{11'd0, 11'd5, 11'd5, 11'd5, 11'd5, 11'd6, 11'd7, 11'd8};
      ts = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      do_reset();
      for (int k = 0; k < 8; k++) begin
         sb.push_back('{ta[k], ts[k], 1'b0, "stall"});
         step(tc[k], 11'd5, 4'h0, tm[k], tk[k]);
         e = sb.pop_front(); n_cmp++;
         if ({oa, os, ot} !== {e.addr, e.stall, e.to}) begin
            n_err++;
            $display("FAIL %s[%0d]: got addr=%h stall=%b timeout=%b, want addr=%h stall=%b timeout=%b", e.tag, k, oa, os, ot, e.addr, e.stall, e.to);
         end
      end
   endtask

   task automatic test_timeout();
      exp_t e;
      do_reset();
      // cycle 0: request, cycles 1..15: WAIT with no ACK, 16: trap vector, 17: trap+1
      for (int k = 0; k < 18; k++) begin
         if (k <= 15)      sb.push_back('{11'd0, 1'b1, 1'b0, "timeout"});
         else if (k == 16) sb.push_back('{11'h7F0, 1'b0, 1'b1, "timeout"});
         else              sb.push_back('{11'h7F1, 1'b0, 1'b0, "timeout"});
         step(3'd0, 11'd0, 4'h0, (k == 0), 1'b0);
         e = sb.pop_front(); n_cmp++;
         if ({oa, os, ot} !== {e.addr, e.stall, e.to}) begin
            n_err++;
            $display("FAIL %s[%0d]: got addr=%h stall=%b timeout=%b, want addr=%h stall=%b timeout=%b", e.tag, k, oa, os, ot, e.addr, e.stall, e.to);
         end
      end
   endtask

   task automatic test_ack_at_limit();
      exp_t e;
      do_reset();
      // ACK arrives on the 15th WAIT cycle (k=15): no trap
      for (int k = 0; k < 18; k++) begin
         if (k <= 14)      sb.push_back('{11'd0, 1'b1, 1'b0, "ack_at_limit"});
         else if (k == 15) sb.push_back('{11'd0, 1'b0, 1'b0, "ack_at_limit"});
         else              sb.push_back('{11'(k - 15), 1'b0, 1'b0, "ack_at_limit"});
         step(3'd0, 11'd0, 4'h0, (k == 0), (k == 15));
         e = sb.pop_front(); n_cmp++;
         if ({oa, os, ot} !== {e.addr, e.stall, e.to}) begin
            n_err++;
            $display("FAIL %s[%0d]: got addr=%h stall=%b timeout=%b, want addr=%h stall=%b timeout=%b", e.tag, k, oa, os, ot, e.addr, e.stall, e.to);
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      exp_t e;
      do_reset();
      // k=0 jump to 0x100, k=1 request, k=2..8 WAIT cycles 0..6, k=9 reset at WAIT cycle 7
      for (int k = 0; k < 20; k++) begin
         rst = (k == 9);
         if (k == 0)      sb.push_back('{11'd0, 1'b0, 1'b0, "reset_mid_wait"});
         else if (k <= 9) sb.push_back('{11'h100, 1'b1, 1'b0, "reset_mid_wait"});
         else             sb.push_back('{11'(k - 10), 1'b0, 1'b0, "reset_mid_wait"});
         step((k == 0) ? 3'd6 : 3'd0, 11'h100, 4'h0, (k == 1), 1'b0);
         e = sb.pop_front(); n_cmp++;
         if ({oa, os, ot} !== {e.addr, e.stall, e.to}) begin
            n_err++;
            $display("FAIL %s[%0d]: got addr=%h stall=%b timeout=%b, want addr=%h stall=%b timeout=%b", e.tag, k, oa, os, ot, e.addr, e.stall, e.to);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_increment();
      test_wrap();
      test_cond_select();
      test_stall();
      test_timeout();
      test_ack_at_limit();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
